adder_tree_loader: RTL

Streaming front end for the 8-operand pipelined adder tree. It collects operands one byte at a time over a valid/ready input stream into an operand bank, drives the bank into a registered 3-stage reduction tree, and returns the sum on a valid/ready output stream. It converts the serial producer side of the accelerator into the parallel operand interface that the tree expects, and hands results back to the serial consumer.

---
 rtl/adder_tree_pkg.sv | 10 +
 rtl/adder_tree_loader_sum8_pipe.sv | 25 ++
 rtl/adder_tree_loader.sv | 92 +++++++++
 3 files changed

// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: shared widths and FSM states for the adder tree loader.
package adder_tree_pkg;
    localparam int W = 8;
    localparam int N = 8;
    localparam int LAT = 3;
    localparam int SUM_W = W + $clog2(N);
    localparam int CNT_W = $clog2(N) + 1;
    localparam int IDX_W = $clog2(N);
    typedef enum logic [1:0] {COLLECT, WAIT, HOLD} state_t;
endpackage

// File: rtl/adder_tree_loader_sum8_pipe.sv
// sum8_pipe: registered 3-stage unsigned reduction tree over eight operands.
module sum8_pipe
    import adder_tree_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0][W-1:0]   op_i,
    output logic [SUM_W-1:0]      sum_o
);
    logic [3:0][W:0]   s1_q;
    logic [1:0][W+1:0] s2_q;
    logic [SUM_W-1:0]  s3_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) s1_q[i] <= {1'b0, op_i[2*i]} + {1'b0, op_i[2*i+1]};
            for (int i = 0; i < 2; i++) s2_q[i] <= {1'b0, s1_q[2*i]} + {1'b0, s1_q[2*i+1]};
            s3_q <= {1'b0, s2_q[0]} + {1'b0, s2_q[1]};
        end
    end
    assign sum_o = s3_q;
endmodule

// File: rtl/adder_tree_loader.sv
// adder_tree_loader: serial valid/ready operand collector feeding sum8_pipe,
// returning the sum and operand count on a valid/ready result stream.
module adder_tree_loader
    import adder_tree_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [W+2:0]     m_sum,
    output logic [3:0]       m_count,
    output logic             m_valid,
    input  logic             m_ready
);
    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [N-1:0][W-1:0]  bank_q, bank_d;
    logic                 s_ready_q, s_ready_d;
    logic                 m_valid_q, m_valid_d;
    logic [CNT_W-1:0]     count_q, count_d;
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        bank_d    = bank_q;
        s_ready_d = s_ready_q;
        m_valid_d = m_valid_q;
        count_d   = count_q;
        case (state_q)
            COLLECT: begin
                s_ready_d = 1'b1;
                if (s_valid && s_ready_q) begin
                    bank_d[idx_q] = s_data;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N - 1) || s_last) begin
                        count_d   = CNT_W'(idx_q) + CNT_W'(1);
                        cnt_d     = 2'(LAT);
                        s_ready_d = 1'b0;
                        state_d   = WAIT;
                    end
                end
            end
            // Counter covers the tree's three capture edges after the final accept.
            WAIT: begin
                cnt_d     = (cnt_q == 2'd1) ? cnt_q : cnt_q - 2'd1;
                m_valid_d = (cnt_q == 2'd1);
                state_d   = (cnt_q == 2'd1) ? HOLD : WAIT;
            end
            HOLD: begin
                if (m_ready) begin
                    bank_d    = '0;
                    idx_d     = '0;
                    m_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    state_d   = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COLLECT;
            idx_q     <= '0;
            cnt_q     <= '0;
            bank_q    <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            bank_q    <= bank_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            count_q   <= count_d;
        end
    end
    sum8_pipe u_tree (
        .clk   (clk),
        .rst   (rst),
        .op_i  (bank_q),
        .sum_o (m_sum)
    );
    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_count = count_q;
endmodule
